// File: rtl/parity_codec_pkg.sv
// Shared constants for the parity codec: parity convention and coded-word layout.
package parity_codec_pkg;

    // Even parity: the parity bit makes the total number of ones even.
    localparam bit          PARITY_EVEN  = 1'b1;
    localparam logic        PARITY_INIT  = PARITY_EVEN ? 1'b0 : 1'b1;

    // Coded word is {payload, parity}: parity at bit 0, payload above it.
    localparam int unsigned PARITY_POS   = 0;
    localparam int unsigned PAYLOAD_LSB  = 1;

endpackage

// File: rtl/parity_codec_if.sv
// Bus bundle for the parity codec: encode path, check path and error status.
interface parity_codec_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]  enc_data;
    logic                   enc_inject;
    logic [DATA_WIDTH:0]    enc_coded;
    logic                   chk_valid;
    logic [DATA_WIDTH:0]    chk_coded;
    logic [DATA_WIDTH-1:0]  chk_data;
    logic                   chk_error;
    logic                   clear;
    logic                   err_sticky;
    logic [COUNT_WIDTH-1:0] err_count;

    modport master (
        output enc_data, enc_inject, chk_valid, chk_coded, clear,
        input  enc_coded, chk_data, chk_error, err_sticky, err_count
    );

    modport slave (
        input  enc_data, enc_inject, chk_valid, chk_coded, clear,
        output enc_coded, chk_data, chk_error, err_sticky, err_count
    );
endinterface

// File: rtl/parity_codec_tree.sv
// XOR-reduction of a vector; shared by the encode and check paths.
module parity_tree #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_parity
);

    assign o_parity = ^i_vec;

endmodule

// File: rtl/parity_codec.sv
// Single-bit parity encoder/checker with sticky error flag and saturating error counter.
module parity_codec
    import parity_codec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    parity_codec_if.slave  bus
);

    localparam int unsigned            CODED_WIDTH = DATA_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

    logic                   w_enc_tree;
    logic                   w_chk_tree;
    logic                   w_enc_parity;
    logic                   w_chk_error;
    logic                   r_err_sticky;
    logic                   w_next_sticky;
    logic [COUNT_WIDTH-1:0] r_err_count;
    logic [COUNT_WIDTH-1:0] w_count_base;
    logic [COUNT_WIDTH-1:0] w_next_count;

    parity_tree #(.WIDTH(DATA_WIDTH)) u_enc_tree (
        .i_vec    (bus.enc_data),
        .o_parity (w_enc_tree)
    );

    parity_tree #(.WIDTH(CODED_WIDTH)) u_chk_tree (
        .i_vec    (bus.chk_coded),
        .o_parity (w_chk_tree)
    );

    // Encode path: fault injection simply inverts the generated parity bit.
    assign w_enc_parity  = w_enc_tree ^ PARITY_INIT ^ bus.enc_inject;
    assign bus.enc_coded = {bus.enc_data, w_enc_parity};

    // Check path: a clean word XORs to the parity convention's initial value.
    assign bus.chk_data  = bus.chk_coded[DATA_WIDTH:PAYLOAD_LSB];
    assign w_chk_error   = (w_chk_tree ^ PARITY_INIT) & bus.chk_valid;
    assign bus.chk_error = w_chk_error;

    // Clear wipes the old status first, then this cycle's error still lands.
    always_comb begin
        w_count_base  = bus.clear ? '0 : r_err_count;
        w_next_count  = w_count_base;
        w_next_sticky = r_err_sticky & ~bus.clear;
        if (w_chk_error) begin
            w_next_sticky = 1'b1;
            if (w_count_base != COUNT_MAX) begin
                w_next_count = w_count_base + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_err_sticky <= w_next_sticky;
            r_err_count  <= w_next_count;
        end
    end

    assign bus.err_sticky = r_err_sticky;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_parity_codec.sv
// Self-checking bench for parity_codec: vector table, corner sequences and random traffic.
module tb_parity_codec;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 4;
    localparam int          MAXC = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] enc_data;
        logic          enc_inject;
        logic          chk_valid;
        logic [DW:0]   chk_coded;
        logic [DW:0]   exp_coded;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   m_count;
    bit   m_sticky;

    parity_codec_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    parity_codec #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: even parity means an odd popcount over the whole coded word is an error.
    function automatic logic ref_parity(input logic [DW-1:0] d);
        return logic'($countones(d) % 2);
    endfunction

    function automatic logic ref_err(input logic valid, input logic [DW:0] c);
        return valid & logic'($countones(c) % 2);
    endfunction

    function automatic logic [DW:0] ref_coded(input logic [DW-1:0] d, input logic inj);
        return {d, ref_parity(d) ^ inj};
    endfunction

    task automatic drive(input logic [DW-1:0] d, input logic inj, input logic v,
                         input logic [DW:0] c, input logic clr);
        bus.enc_data   = d;
        bus.enc_inject = inj;
        bus.chk_valid  = v;
        bus.chk_coded  = c;
        bus.clear      = clr;
    endtask

    task automatic check_comb(input string tag);
        check({tag, ".enc_coded"}, 64'(bus.enc_coded), 64'(ref_coded(bus.enc_data, bus.enc_inject)));
        check({tag, ".chk_data"},  64'(bus.chk_data),  64'(bus.chk_coded >> 1));
        check({tag, ".chk_error"}, 64'(bus.chk_error), 64'(ref_err(bus.chk_valid, bus.chk_coded)));
    endtask

    // Advance one clock, step the status model with the bench's own error prediction, compare.
    task automatic tick(input string tag);
        logic e;
        logic c;
        e = ref_err(bus.chk_valid, bus.chk_coded);
        c = bus.clear;
        @(posedge clk);
        #1;
        if (c) begin
            m_count  = 0;
            m_sticky = 1'b0;
        end
        if (e) begin
            m_sticky = 1'b1;
            if (m_count < MAXC) m_count++;
        end
        check({tag, ".err_sticky"}, 64'(bus.err_sticky), 64'(m_sticky));
        check({tag, ".err_count"},  64'(bus.err_count),  64'(m_count));
    endtask

    vec_t vecs[7];

    initial begin
        logic [DW:0]   w;
        logic [DW-1:0] d;
        n_checks = 0;
        n_errors = 0;
        m_count  = 0;
        m_sticky = 1'b0;

        vecs[0] = '{32'h0000_0000, 1'b0, 1'b1, 33'h0_0000_0000, 33'h0_0000_0000, 32'h0000_0000, 1'b0};
        vecs[1] = '{32'h0000_0001, 1'b0, 1'b1, 33'h0_0000_0003, 33'h0_0000_0003, 32'h0000_0001, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 33'h0_0000_0001, 33'h1_FFFF_FFFE, 32'h0000_0000, 1'b0};
        vecs[3] = '{32'h0000_0001, 1'b1, 1'b1, 33'h0_0000_0002, 33'h0_0000_0002, 32'h0000_0001, 1'b1};
        vecs[4] = '{32'h8000_0000, 1'b0, 1'b1, 33'h1_FFFF_FFFF, 33'h1_0000_0001, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{32'h0000_000F, 1'b0, 1'b1, 33'h0_0000_001E, 33'h0_0000_001E, 32'h0000_000F, 1'b0};
        vecs[6] = '{32'h0000_0007, 1'b0, 1'b1, 33'h0_0000_000F, 33'h0_0000_000F, 32'h0000_0007, 1'b0};

        reset = 1'b1;
        drive('0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        check("reset.err_sticky", 64'(bus.err_sticky), 64'(0));
        check("reset.err_count",  64'(bus.err_count),  64'(0));
        #10;
        reset = 1'b0;

        // Table of fixed vectors.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].enc_data, vecs[i].enc_inject, vecs[i].chk_valid, vecs[i].chk_coded, 1'b0);
            #1;
            check($sformatf("vec%0d.enc_coded", i), 64'(bus.enc_coded), 64'(vecs[i].exp_coded));
            check($sformatf("vec%0d.chk_data", i),  64'(bus.chk_data),  64'(vecs[i].exp_data));
            check($sformatf("vec%0d.chk_error", i), 64'(bus.chk_error), 64'(vecs[i].exp_err));
            tick($sformatf("vec%0d", i));
        end

        // Injected fault looped from encoder into checker.
        drive('0, 1'b0, 1'b0, '0, 1'b1);
        tick("clr0");
        drive(32'h1, 1'b1, 1'b1, '0, 1'b0);
        #1;
        bus.chk_coded = bus.enc_coded;
        #1;
        check("loop.chk_error", 64'(bus.chk_error), 64'(1));
        tick("loop");
        check("loop.count1", 64'(bus.err_count), 64'(1));
        bus.chk_valid = 1'b0;
        #1;
        check("loop_nv.chk_error", 64'(bus.chk_error), 64'(0));
        tick("loop_nv");
        check("loop_nv.count_held", 64'(bus.err_count), 64'(1));

        // Saturation: 20 consecutive errors then idle.
        drive('0, 1'b0, 1'b1, 33'h1, 1'b1);
        tick("sat_first");
        bus.clear = 1'b0;
        for (int i = 1; i < 20; i++) tick($sformatf("sat%0d", i));
        check("sat.max", 64'(bus.err_count), 64'(MAXC));
        bus.chk_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick($sformatf("sat_hold%0d", i));
        check("sat.held", 64'(bus.err_count), 64'(MAXC));

        // Clear alone, five errors, then clear together with an error.
        drive('0, 1'b0, 1'b0, '0, 1'b1);
        tick("clr_only");
        drive('0, 1'b0, 1'b1, 33'h4, 1'b0);
        for (int i = 0; i < 5; i++) tick($sformatf("five%0d", i));
        check("five.count", 64'(bus.err_count), 64'(5));
        bus.clear = 1'b1;
        tick("clr_err");
        check("clr_err.count", 64'(bus.err_count), 64'(1));
        check("clr_err.sticky", 64'(bus.err_sticky), 64'(1));
        bus.clear = 1'b0;
        tick("post_clr");

        // Reset between edges: status drops at once, combinational paths untouched.
        drive(32'h0000_0003, 1'b1, 1'b1, 33'h0_0000_0007, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        m_count  = 0;
        m_sticky = 1'b0;
        check("midrst.err_sticky", 64'(bus.err_sticky), 64'(0));
        check("midrst.err_count",  64'(bus.err_count),  64'(0));
        check("midrst.enc_coded",  64'(bus.enc_coded),  64'(33'h0_0000_0007));
        check("midrst.chk_data",   64'(bus.chk_data),   64'(32'h0000_0003));
        check("midrst.chk_error",  64'(bus.chk_error),  64'(1));
        @(posedge clk);
        #1;
        check("inrst.err_count", 64'(bus.err_count), 64'(0));
        #2;
        reset = 1'b0;
        tick("after_rst");
        check("after_rst.count", 64'(bus.err_count), 64'(1));

        // Random traffic against the popcount model.
        for (int i = 0; i < 300; i++) begin
            d = $urandom();
            if ($urandom_range(0, 3) == 0) begin
                w = {1'($urandom()), 32'($urandom())};
            end else begin
                w = ref_coded(d, 1'b0);
                for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                    w[$urandom_range(0, DW)] ^= 1'b1;
            end
            drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
                  1'($urandom_range(0, 9) == 0));
            #1;
            check_comb($sformatf("rnd%0d", i));
            tick($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parity_codec.md
PARITY_CODEC -- requirements
Module: parity_codec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits (legal range 1..1024).
REQ-002 SHALL have parameter COUNT_WIDTH, default 16, giving the width of the error counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enc_data, input, DATA_WIDTH bits: the payload to encode.
REQ-006 SHALL have port enc_inject, input, 1 bit: when 1, inverts the generated parity bit (fault injection).
REQ-007 SHALL have port enc_coded, output, DATA_WIDTH+1 bits: the coded word {payload, parity}.
REQ-008 SHALL have port chk_valid, input, 1 bit: qualifies the check path this cycle.
REQ-009 SHALL have port chk_coded, input, DATA_WIDTH+1 bits: the coded word to check.
REQ-010 SHALL have port chk_data, output, DATA_WIDTH bits: the payload extracted from chk_coded.
REQ-011 SHALL have port chk_error, output, 1 bit: combinational parity mismatch, qualified by chk_valid.
REQ-012 SHALL have port clear, input, 1 bit: synchronous clear of the error status.
REQ-013 SHALL have port err_sticky, output, 1 bit: registered; set by any qualified error.
REQ-014 SHALL have port err_count, output, COUNT_WIDTH bits: registered saturating count of qualified errors.

Function
REQ-015 SHALL use even parity: parity bit = XOR-reduction of the payload.
REQ-016 SHALL drive enc_coded[DATA_WIDTH:1] = enc_data and enc_coded[0] = parity XOR enc_inject, combinationally (zero latency).
REQ-017 SHALL drive chk_data = chk_coded[DATA_WIDTH:1] combinationally, regardless of chk_valid or error.
REQ-018 SHALL compute the raw error as the XOR-reduction of all DATA_WIDTH+1 bits of chk_coded, and drive chk_error = raw error AND chk_valid, combinationally.
REQ-019 SHALL detect every odd number of flipped bits, and SHALL NOT flag an even number of flipped bits (inherent to single parity).
REQ-020 SHALL treat an all-zero coded word as valid (no error), so zero-initialised storage checks clean.
REQ-021 SHALL, at each rising clk edge: if clear=1, reset err_sticky to 0 and err_count to 0, then apply the current cycle's chk_error.
REQ-022 SHALL, when chk_error=1 at a rising edge, set err_sticky to 1 and increment err_count by 1.
REQ-023 SHALL saturate err_count at all-ones; it SHALL NOT wrap.
REQ-024 SHALL, when clear and chk_error are both 1 in the same cycle, give err_sticky=1 and err_count=1 on the next cycle.
REQ-025 SHALL leave the status registers unchanged when chk_valid=0, whatever the value of chk_coded.
REQ-026 SHALL keep the encode and check paths fully independent, so both may be used in the same cycle.

Reset
REQ-027 SHALL, while reset=1, asynchronously force err_sticky=0 and err_count=0, and hold them there until reset is deasserted.
REQ-028 SHALL NOT let reset affect the combinational outputs enc_coded, chk_data and chk_error.
REQ-029 SHALL resume counting errors on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place the parity convention (even) and the coded-word bit layout (parity at bit 0) as constants in the shared defines package.
REQ-031 SHALL implement the XOR-reduction in one sub-module, parity_tree (parameter WIDTH, input vector, output 1-bit parity), instantiated once for encode and once for check.
REQ-032 SHALL contain no memories and no state other than err_sticky and err_count.

Verification
REQ-033 SHALL cover encode with DATA_WIDTH=32: enc_data=0x00000000 -> enc_coded=33'h000000000; enc_data=0x00000001 -> 33'h000000003; enc_data=0xFFFFFFFF -> 33'h1FFFFFFFE.
REQ-034 SHALL cover a clean check: chk_valid=1, chk_coded=33'h000000003 -> chk_data=0x00000001, chk_error=0, err_count stays 0.
REQ-035 SHALL cover a faulty check: enc_inject=1 with enc_data=0x1, enc_coded looped into chk_coded, chk_valid=1 -> chk_error=1 in the same cycle, then err_sticky=1 and err_count=1 on the next cycle; with chk_valid=0 and the same word -> chk_error=0 and no count change.
REQ-036 SHALL cover saturation: COUNT_WIDTH=4, 20 consecutive erroneous checks -> err_count=0xF and held.
REQ-037 SHALL cover clear and error in the same cycle with err_count=5 -> err_count=1, err_sticky=1.
REQ-038 SHALL cover reset asserted mid-stream between clock edges -> err_sticky and err_count read 0 immediately, and the encode/check outputs stay unchanged.
